// File: rtl/morph_pkg.sv
// Shared definitions for the morphological edge-enhance pipeline: mode encoding
// and the clamped-at-zero subtractor used for the dilate/erode residues.
package morph_pkg;

   typedef enum logic [1:0] {
      MODE_ENH  = 2'd0,
      MODE_GRAD = 2'd1,
      MODE_MAX  = 2'd2,
      MODE_BYP  = 2'd3
   } mode_e;

   // Wide enough for the largest supported pixel; callers resize in and out.
   localparam int unsigned ARITH_W = 16;

   function automatic logic [ARITH_W-1:0] sat_sub(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

endpackage

// File: rtl/morph_edge_lane.sv
// Per-lane combinational edge arithmetic between S1 and S2: mode select,
// gain-shifted residue difference and clipping to the pixel range.
module morph_edge_lane
   import morph_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] yd,
   input  logic [DATA_W-1:0] ye,
   input  logic [DATA_W-1:0] pixel,
   input  mode_e             mode,
   input  logic [2:0]        gain_sh,
   output logic [DATA_W-1:0] result,
   output logic              sat
);

   localparam int unsigned SW = DATA_W + 2;

   logic [DATA_W-1:0] emax;
   logic [DATA_W-1:0] emin;
   logic [DATA_W-1:0] diff;
   logic [SW-1:0]     sum;

   always_comb begin
      emax = (yd > ye) ? yd : ye;
      emin = (yd > ye) ? ye : yd;
      diff = emax - emin;
      sum  = '0;
      case (mode)
         MODE_ENH:  sum = SW'(yd) + SW'(ye) + SW'(diff >> gain_sh);
         MODE_GRAD: sum = SW'(yd) + SW'(ye);
         MODE_MAX:  sum = SW'(emax);
         MODE_BYP:  sum = SW'(pixel);
         default:   sum = '0;
      endcase
      sat    = (sum > SW'({DATA_W{1'b1}}));
      result = sat ? '1 : sum[DATA_W-1:0];
   end

endmodule

// File: rtl/morph_edge_enhance_pipe.sv
// Two-stage pipelined morphological edge enhancer with valid/ready flow control
// and per-frame saturation statistics. Define EDGE_THRESH_EN for binary thresholding.
module morph_edge_enhance_pipe
   import morph_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANES  = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [LANES*DATA_W-1:0]  in_pixel,
   input  logic [LANES*DATA_W-1:0]  in_dilate,
   input  logic [LANES*DATA_W-1:0]  in_erode,
   input  logic [1:0]               cfg_mode,
   input  logic [2:0]               cfg_gain_sh,
`ifdef EDGE_THRESH_EN
   input  logic [DATA_W-1:0]        cfg_thresh,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic [LANES*DATA_W-1:0]  out_edge,
   output logic [CNT_W-1:0]         sat_count,
   output logic                     sat_count_vld
);

   localparam int unsigned SC_W = $clog2(LANES + 1);

   logic                    adv;
   logic                    fire;

   logic                    s1_valid_q;
   logic                    s1_last_q;
   logic [LANES*DATA_W-1:0] s1_yd_q, s1_yd_d;
   logic [LANES*DATA_W-1:0] s1_ye_q, s1_ye_d;
   logic [LANES*DATA_W-1:0] s1_pix_q;
   mode_e                   s1_mode_q;
   logic [2:0]              s1_gain_q;
`ifdef EDGE_THRESH_EN
   logic [DATA_W-1:0]       s1_thresh_q;
`endif

   logic [LANES*DATA_W-1:0] lane_res;
   logic [LANES-1:0]        lane_sat;

   logic                    out_valid_q;
   logic                    out_last_q;
   logic [LANES*DATA_W-1:0] out_edge_q, out_edge_d;
   logic [SC_W-1:0]         nsat_q, nsat_d;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W:0]          cnt_sum;
   logic [CNT_W-1:0]        sat_count_q;
   logic                    sat_count_vld_q;

   // Both stages advance together so S1 bubbles are preserved under stall.
   assign adv       = !out_valid_q || out_ready;
   assign fire      = out_valid_q && out_ready;
   assign in_ready  = adv;

   assign out_valid     = out_valid_q;
   assign out_last      = out_last_q;
   assign out_edge      = out_edge_q;
   assign sat_count     = sat_count_q;
   assign sat_count_vld = sat_count_vld_q;

   always_comb begin
      s1_yd_d = '0;
      s1_ye_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         s1_yd_d[i*DATA_W +: DATA_W] = DATA_W'(sat_sub(ARITH_W'(in_dilate[i*DATA_W +: DATA_W]),
                                                       ARITH_W'(in_pixel[i*DATA_W +: DATA_W])));
         s1_ye_d[i*DATA_W +: DATA_W] = DATA_W'(sat_sub(ARITH_W'(in_pixel[i*DATA_W +: DATA_W]),
                                                       ARITH_W'(in_erode[i*DATA_W +: DATA_W])));
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      morph_edge_lane #(.DATA_W(DATA_W)) u_lane (
         .yd      (s1_yd_q[g*DATA_W +: DATA_W]),
         .ye      (s1_ye_q[g*DATA_W +: DATA_W]),
         .pixel   (s1_pix_q[g*DATA_W +: DATA_W]),
         .mode    (s1_mode_q),
         .gain_sh (s1_gain_q),
         .result  (lane_res[g*DATA_W +: DATA_W]),
         .sat     (lane_sat[g])
      );
   end

   always_comb begin
      out_edge_d = lane_res;
      nsat_d     = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
`ifdef EDGE_THRESH_EN
         if (s1_mode_q != MODE_BYP) begin
            out_edge_d[i*DATA_W +: DATA_W] =
               (lane_res[i*DATA_W +: DATA_W] >= s1_thresh_q) ? '1 : '0;
         end
`endif
         nsat_d = nsat_d + SC_W'(lane_sat[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_yd_q     <= '0;
         s1_ye_q     <= '0;
         s1_pix_q    <= '0;
         s1_mode_q   <= MODE_ENH;
         s1_gain_q   <= '0;
`ifdef EDGE_THRESH_EN
         s1_thresh_q <= '0;
`endif
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_edge_q  <= '0;
         nsat_q      <= '0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s1_last_q   <= in_valid && in_last;
         s1_yd_q     <= s1_yd_d;
         s1_ye_q     <= s1_ye_d;
         s1_pix_q    <= in_pixel;
         s1_mode_q   <= mode_e'(cfg_mode);
         s1_gain_q   <= cfg_gain_sh;
`ifdef EDGE_THRESH_EN
         s1_thresh_q <= cfg_thresh;
`endif
         out_valid_q <= s1_valid_q;
         out_last_q  <= s1_valid_q && s1_last_q;
         out_edge_q  <= out_edge_d;
         nsat_q      <= s1_valid_q ? nsat_d : '0;
      end
   end

   // Running total clips at all-ones rather than wrapping.
   always_comb begin
      cnt_sum = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(nsat_q);
      cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q           <= '0;
         sat_count_q     <= '0;
         sat_count_vld_q <= 1'b0;
      end else begin
         sat_count_vld_q <= 1'b0;
         if (fire) begin
            if (out_last_q) begin
               sat_count_q     <= cnt_d;
               sat_count_vld_q <= 1'b1;
               cnt_q           <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   end

endmodule

// File: doc/morph_edge_enhance_pipe.md
Name: morph_edge_enhance_pipe

Overview:
Pipelined, parametrised successor to the combinational morphological edge enhancer.
- Takes a stream of (pixel, dilate, erode) beats, LANES pixels per beat, each DATA_W bits.
- Computes per-lane edge response in one of four runtime modes, with runtime-programmable diff gain.
- Uses valid/ready streaming with backpressure and per-frame saturation statistics.
- Sits between the multiscale dilate/erode stage and the output formatter.

Parameters:
DATA_W, 8, pixel bit width (4..16)
LANES, 1, pixels per beat (1..8)
CNT_W, 16, width of saturation counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
in_last  in  1  last beat of frame
in_pixel  in  LANES*DATA_W  original pixels, lane 0 in LSBs
in_dilate  in  LANES*DATA_W  dilated pixels
in_erode  in  LANES*DATA_W  eroded pixels
cfg_mode  in  2  0=enhance, 1=gradient, 2=max-residue, 3=bypass
cfg_gain_sh  in  3  right-shift applied to diff in enhance mode
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_last  out  1  frame end, aligned with beat
out_edge  out  LANES*DATA_W  edge result per lane
sat_count  out  CNT_W  saturated-lane count of last completed frame
sat_count_vld  out  1  one-cycle pulse when sat_count updates

Behaviour:
- Reset (rst_n low, async): all stage valids, out_valid, out_last, out_edge, sat_count, sat_count_vld and the running counter are 0. in_ready is 1 after reset.
- Per lane, MAX = 2^DATA_W-1:
  - yd = dilate>pixel ? dilate-pixel : 0
  - ye = pixel>erode ? pixel-erode : 0
  - emax/emin = max/min(yd,ye); diff = emax-emin
- Mode results:
  - Mode 0: sum = yd+ye+(diff>>cfg_gain_sh), computed at DATA_W+2 bits.
  - Mode 1: sum = yd+ye.
  - Mode 2: sum = emax.
  - Mode 3: sum = pixel.
- Saturation: result = sum>MAX ? MAX : sum; a lane is saturated when sum>MAX. Modes 2 and 3 never saturate.
- Config sampling: cfg_mode and cfg_gain_sh are captured with each accepted beat and travel with it. Changes take effect on the next accepted beat.
- Pipeline: two register stages.
  - S1 registers yd, ye and the config.
  - S2 registers the saturated result, per-beat saturation count and last.
  - Latency is exactly 2 cycles from input acceptance to out_valid when unstalled.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv.
  - Both stages load only when adv = 1, so bubbles in S1 are not collapsed during a stall.
  - out_* stay stable while out_valid && !out_ready.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Statistics:
  - The running counter adds the number of saturated lanes of each beat as it leaves S2 (out_valid && out_ready). It saturates at 2^CNT_W-1 and does not wrap.
  - On the output handshake of a beat with out_last=1, sat_count is loaded with the running total including that beat, sat_count_vld pulses for 1 cycle, and the running counter clears to 0.
  - A last beat that has saturated lanes, followed by a first beat in the next cycle: the new frame's count starts from 0.
- rst_n asserted mid-frame: in-flight beats are discarded and no out_valid is produced for them.

Optional Feature:
EDGE_THRESH_EN
- Defined: adds input port cfg_thresh (DATA_W). In modes 0 to 2, out_edge lane = (result >= cfg_thresh) ? MAX : 0, applied in S2 with latency unchanged. cfg_thresh is sampled with the beat. Saturation counting uses the pre-threshold sum.
- Undefined: port absent; out_edge carries the raw result.

Decomposition:
- Package morph_pkg: mode encoding constants (MODE_ENH, MODE_GRAD, MODE_MAX, MODE_BYP) and a function sat_sub(a,b).
- Sub-module morph_edge_lane: combinational per-lane S1-to-S2 arithmetic (inputs yd, ye, pixel, mode, gain_sh; outputs result, sat). Instantiated LANES times in a generate loop.

Test Plan:
- Mode 0, gain_sh=1, pixel=100, dilate=180, erode=90 -> out_edge=125 two cycles after acceptance, not saturated.
- Mode 0, gain_sh=1, pixel=10, dilate=255, erode=0 -> sum 372 clipped to 255; frame of 4 such beats with last on beat 4 -> sat_count=4, one sat_count_vld pulse.
- Same first stimulus, gain_sh=3 -> 98; mode 1 -> 90; mode 2 -> 80; mode 3 -> 100. Mode switched on consecutive beats -> each beat uses its own mode.
- out_ready low for 5 cycles during a continuous stream -> in_ready low; out_edge and out_last stable; no beat lost or duplicated; order preserved on release.
- LANES=4, DATA_W=10, lanes saturating on {lane0, lane3} for 3 beats -> sat_count=6; counter preload near 2^CNT_W-1 -> holds at max.
- rst_n pulsed low with 2 beats in flight -> out_valid=0, sat_count=0 immediately (async); first beat after release is output cleanly.
